// File: rtl/ic_biu_pkg.sv
// Shared definitions for the instruction-cache Wishbone bus interface unit.
//   biu_state_e    : FSM state encoding (IDLE, ACTIVE)
//   CTI_* / BTE_*  : Wishbone B3 cycle-type and burst-type codes
//   bte_for()      : wrap burst type matching a refill line length
package ic_biu_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } biu_state_e;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;

   // A 2-word line has no wrap code; it is issued as a linear burst.
   function automatic logic [1:0] bte_for(input int unsigned words);
      case (words)
         4:       return BTE_WRAP4;
         8:       return BTE_WRAP8;
         default: return BTE_LINEAR;
      endcase
   endfunction

endpackage

// File: rtl/ic_biu_wrap_addr.sv
// Beat counter and wrapping word-address incrementer for line refills.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture load_addr (word aligned) and the beat count
//   step       : advance to the next word inside the line, count down
//   burst      : at load, 1 = LINE_WORDS beats, 0 = single beat
//   load_addr  : start byte address
//   adr        : current beat address
//   last       : current beat is the final one of the transfer
module ic_biu_wrap_addr #(
   parameter int AW         = 32,
   parameter int LINE_WORDS = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          step,
   input  logic          burst,
   input  logic [AW-1:0] load_addr,
   output logic [AW-1:0] adr,
   output logic          last
);

   // Word-offset bits inside a line; also wide enough for LINE_WORDS-1.
   localparam int OW = $clog2(LINE_WORDS);

   logic [AW-1:0] adr_q, adr_d;
   logic [OW-1:0] cnt_q, cnt_d;

   always_comb begin
      adr_d = adr_q;
      cnt_d = cnt_q;
      if (load) begin
         adr_d = load_addr & ~AW'(3);
         cnt_d = burst ? OW'(LINE_WORDS - 1) : '0;
      end else if (step) begin
         // Only the in-line offset moves, so the carry never leaves the line.
         adr_d[OW+1:2] = adr_q[OW+1:2] + OW'(1);
         cnt_d         = cnt_q - OW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         adr_q <= '0;
         cnt_q <= '0;
      end else begin
         adr_q <= adr_d;
         cnt_q <= cnt_d;
      end
   end

   assign adr  = adr_q;
   assign last = (cnt_q == '0);

endmodule

// File: rtl/ic_wb_burst_biu.sv
// Instruction-cache bus interface unit: turns the line-fill FSM's read request
// into Wishbone read cycles (single beat, or LINE_WORDS-beat wrapping refill)
// and returns each beat / bus error to the FSM.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   biu_read, burst,
//   saved_addr               : request from the line-fill FSM
//   biudata, biudata_valid,
//   biudata_error            : beat data / accept / error back to the FSM
//   wb_*                     : Wishbone master (read only)
// Build option IC_BIU_WB_B3_EN: drive registered-feedback cti/bte codes;
// without it every cycle is a classic cycle (cti=000, bte=00).
//
// state  | meaning
// IDLE   | no bus cycle; a request loads address/count and starts next edge
// ACTIVE | cyc/stb high; waiting for ack/err, or abort when biu_read drops
module ic_wb_burst_biu
   import ic_biu_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int LINE_WORDS = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          biu_read,
   input  logic          burst,
   input  logic [AW-1:0] saved_addr,
   output logic [DW-1:0] biudata,
   output logic          biudata_valid,
   output logic          biudata_error,
   output logic          wb_cyc_o,
   output logic          wb_stb_o,
   output logic          wb_we_o,
   output logic [3:0]    wb_sel_o,
   output logic [AW-1:0] wb_adr_o,
   output logic [2:0]    wb_cti_o,
   output logic [1:0]    wb_bte_o,
   input  logic [DW-1:0] wb_dat_i,
   input  logic          wb_ack_i,
   input  logic          wb_err_i
);

   localparam logic [0:0] S_IDLE   = IDLE;
   localparam logic [0:0] S_ACTIVE = ACTIVE;

   logic [0:0] state_q, state_d;
   logic       burst_q, burst_d;
   logic       load, step, last, active;

   assign active = (state_q == S_ACTIVE);

   always_comb begin
      state_d = state_q;
      burst_d = burst_q;
      load    = 1'b0;
      step    = 1'b0;
      if (!active) begin
         if (biu_read) begin
            state_d = S_ACTIVE;
            burst_d = burst;
            load    = 1'b1;
         end
      end else if (!biu_read || wb_err_i) begin
         state_d = S_IDLE;
      end else if (wb_ack_i) begin
         if (last) state_d = S_IDLE;
         else      step    = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         burst_q <= 1'b0;
      end else begin
         state_q <= state_d;
         burst_q <= burst_d;
      end
   end

   ic_biu_wrap_addr #(
      .AW         (AW),
      .LINE_WORDS (LINE_WORDS)
   ) u_wrap_addr (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .step      (step),
      .burst     (burst),
      .load_addr (saved_addr),
      .adr       (wb_adr_o),
      .last      (last)
   );

   // An abort (biu_read low) swallows any ack/err arriving in the same cycle.
   assign biudata       = wb_dat_i;
   assign biudata_error = active & biu_read & wb_err_i;
   assign biudata_valid = active & biu_read & ~wb_err_i & wb_ack_i;

   assign wb_cyc_o = active;
   assign wb_stb_o = active;
   assign wb_we_o  = 1'b0;
   assign wb_sel_o = 4'hF;

`ifdef IC_BIU_WB_B3_EN
   always_comb begin
      wb_cti_o = CTI_CLASSIC;
      wb_bte_o = BTE_LINEAR;
      if (active) begin
         if (burst_q) begin
            wb_cti_o = last ? CTI_EOB : CTI_INCR;
            wb_bte_o = bte_for(LINE_WORDS);
         end else begin
            wb_cti_o = CTI_EOB;
         end
      end
   end
`else
   assign wb_cti_o = CTI_CLASSIC;
   assign wb_bte_o = BTE_LINEAR;
`endif

endmodule

// File: tb/tb_ic_wb_burst_biu.sv
module tb_ic_wb_burst_biu;

   localparam int LW = 4;
`ifdef IC_BIU_WB_B3_EN
   localparam bit B3 = 1'b1;
`else
   localparam bit B3 = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        biu_read = 1'b0;
   logic        burst = 1'b0;
   logic [31:0] saved_addr = '0;
   logic [31:0] biudata;
   logic        biudata_valid, biudata_error;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_adr_o;
   logic [2:0]  wb_cti_o;
   logic [1:0]  wb_bte_o;
   logic [31:0] wb_dat_i = '0;
   logic        wb_ack_i = 1'b0;
   logic        wb_err_i = 1'b0;

   ic_wb_burst_biu #(.AW(32), .DW(32), .LINE_WORDS(LW)) dut (
      .clk(clk), .rst(rst), .biu_read(biu_read), .burst(burst), .saved_addr(saved_addr),
      .biudata(biudata), .biudata_valid(biudata_valid), .biudata_error(biudata_error),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
      .wb_adr_o(wb_adr_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Transfer-level model: is a transfer open, where does its line start,
   // which word did it start at, how many beats done, how many in total.
   bit          m_act   = 1'b0;
   bit          m_burst = 1'b0;
   logic [31:0] m_base  = '0;
   int          m_start = 0;
   int          m_k     = 0;
   int          m_n     = 0;
   logic [31:0] m_adr   = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] beat_adr(input logic [31:0] base, input int start, input int k);
      return base + 32'(((start + k) % LW) * 4);
   endfunction

   function automatic logic [2:0] exp_cti();
      if (!B3 || !m_act) return 3'b000;
      if (!m_burst)      return 3'b111;
      return (m_k == m_n - 1) ? 3'b111 : 3'b010;
   endfunction

   function automatic logic [1:0] exp_bte();
      if (!B3 || !m_act || !m_burst) return 2'b00;
      return (LW == 4) ? 2'b01 : (LW == 8) ? 2'b10 : 2'b00;
   endfunction

   task automatic model_reset();
      m_act = 1'b0; m_burst = 1'b0; m_k = 0; m_n = 0; m_adr = '0;
   endtask

   // One bus cycle: drive inputs after the falling edge, compare every
   // output against the model, then advance the model to the next cycle.
   task automatic step(input bit rd, input bit bst, input logic [31:0] addr,
                       input bit ack, input bit err, input logic [31:0] dat);
      bit ev, ee;
      @(negedge clk);
      biu_read = rd; burst = bst; saved_addr = addr;
      wb_ack_i = ack; wb_err_i = err; wb_dat_i = dat;
      #1;
      ev = m_act && rd && !err && ack;
      ee = m_act && rd && err;
      chk("cyc",   32'(wb_cyc_o), 32'(m_act));
      chk("stb",   32'(wb_stb_o), 32'(m_act));
      chk("adr",   wb_adr_o, m_adr);
      chk("cti",   32'(wb_cti_o), 32'(exp_cti()));
      chk("bte",   32'(wb_bte_o), 32'(exp_bte()));
      chk("valid", 32'(biudata_valid), 32'(ev));
      chk("error", 32'(biudata_error), 32'(ee));
      chk("we",    32'(wb_we_o), 32'd0);
      chk("sel",   32'(wb_sel_o), 32'hF);
      if (ev) chk("data", biudata, dat);
      if (!m_act) begin
         if (rd) begin
            m_act   = 1'b1;
            m_burst = bst;
            m_base  = addr & ~32'(LW * 4 - 1);
            m_start = int'((addr >> 2) % LW);
            m_k     = 0;
            m_n     = bst ? LW : 1;
            m_adr   = beat_adr(m_base, m_start, 0);
         end
      end else if (!rd || err) begin
         m_act = 1'b0;
      end else if (ack) begin
         m_k++;
         if (m_k == m_n) m_act = 1'b0;
         else            m_adr = beat_adr(m_base, m_start, m_k);
      end
   endtask

   initial begin
      logic [31:0] wrap_adr [4];
      logic [2:0]  wrap_cti [4];
      wrap_adr[0] = 32'h1008; wrap_adr[1] = 32'h100C;
      wrap_adr[2] = 32'h1000; wrap_adr[3] = 32'h1004;
      wrap_cti[0] = B3 ? 3'b010 : 3'b000; wrap_cti[1] = wrap_cti[0];
      wrap_cti[2] = wrap_cti[0];          wrap_cti[3] = B3 ? 3'b111 : 3'b000;

      // Reset values
      model_reset();
      @(negedge clk); #1;
      chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
      chk("rst_stb", 32'(wb_stb_o), 32'd0);
      chk("rst_adr", wb_adr_o, 32'd0);
      chk("rst_cti", 32'(wb_cti_o), 32'd0);
      chk("rst_bte", 32'(wb_bte_o), 32'd0);
      @(negedge clk); rst = 1'b0;

      // 1 single beat
      step(1, 0, 32'h0000_0100, 0, 0, 32'h0);
      step(1, 0, 32'h0000_0100, 1, 0, 32'hDEADBEEF);
      chk("t1_adr", wb_adr_o, 32'h100);
      chk("t1_cti", 32'(wb_cti_o), B3 ? 32'h7 : 32'h0);
      chk("t1_valid", 32'(biudata_valid), 32'd1);
      chk("t1_data", biudata, 32'hDEADBEEF);
      step(0, 0, 32'h0, 0, 0, 32'h0);
      chk("t1_cyc_end", 32'(wb_cyc_o), 32'd0);

      // 2 wrapping burst from 0x1008
      step(1, 1, 32'h0000_1008, 0, 0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 32'h0000_1008, 1, 0, 32'hA000_0000 + 32'(i));
         chk("t2_adr", wb_adr_o, wrap_adr[i]);
         chk("t2_cti", 32'(wb_cti_o), 32'(wrap_cti[i]));
         chk("t2_bte", 32'(wb_bte_o), B3 ? 32'h1 : 32'h0);
         chk("t2_valid", 32'(biudata_valid), 32'd1);
      end
      step(0, 0, 32'h0, 0, 0, 32'h0);
      chk("t2_cyc_end", 32'(wb_cyc_o), 32'd0);

      // 3 error on beat 2
      step(1, 1, 32'h0000_0500, 0, 0, 32'h0);
      step(1, 1, 32'h0000_0500, 1, 0, 32'h11);
      step(1, 1, 32'h0000_0500, 0, 1, 32'h22);
      chk("t3_error", 32'(biudata_error), 32'd1);
      chk("t3_valid", 32'(biudata_valid), 32'd0);
      step(0, 0, 32'h0, 1, 0, 32'h33);
      chk("t3_cyc_end", 32'(wb_cyc_o), 32'd0);
      chk("t3_no_beat3", 32'(biudata_valid), 32'd0);

      // 4 abort after beat 1, then a clean request at 0x2000
      step(1, 1, 32'h0000_3000, 0, 0, 32'h0);
      step(1, 1, 32'h0000_3000, 1, 0, 32'h44);
      step(0, 1, 32'h0000_3000, 1, 0, 32'h55);
      chk("t4_abort_valid", 32'(biudata_valid), 32'd0);
      step(0, 0, 32'h0, 0, 0, 32'h0);
      chk("t4_cyc_end", 32'(wb_cyc_o), 32'd0);
      step(1, 0, 32'h0000_2000, 0, 0, 32'h0);
      step(1, 0, 32'h0000_2000, 1, 0, 32'h66);
      chk("t4_adr", wb_adr_o, 32'h2000);
      chk("t4_valid", 32'(biudata_valid), 32'd1);
      step(0, 0, 32'h0, 0, 0, 32'h0);

      // 5 reset during a stalled beat 3
      step(1, 1, 32'h0000_0700, 0, 0, 32'h0);
      step(1, 1, 32'h0000_0700, 1, 0, 32'h1);
      step(1, 1, 32'h0000_0700, 1, 0, 32'h2);
      step(1, 1, 32'h0000_0700, 0, 0, 32'h3);
      rst = 1'b1; #1;
      chk("t5_cyc", 32'(wb_cyc_o), 32'd0);
      chk("t5_stb", 32'(wb_stb_o), 32'd0);
      chk("t5_valid", 32'(biudata_valid), 32'd0);
      chk("t5_error", 32'(biudata_error), 32'd0);
      model_reset();
      biu_read = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      step(1, 0, 32'h0000_0040, 0, 0, 32'h0);
      step(1, 0, 32'h0000_0040, 1, 0, 32'h77);
      chk("t5_after_valid", 32'(biudata_valid), 32'd1);
      chk("t5_after_adr", wb_adr_o, 32'h40);
      step(0, 0, 32'h0, 0, 0, 32'h0);

      // 6 ack and err together
      step(1, 1, 32'h0000_0600, 0, 0, 32'h0);
      step(1, 1, 32'h0000_0600, 1, 1, 32'h88);
      chk("t6_error", 32'(biudata_error), 32'd1);
      chk("t6_valid", 32'(biudata_valid), 32'd0);
      step(0, 0, 32'h0, 0, 0, 32'h0);
      chk("t6_cyc_end", 32'(wb_cyc_o), 32'd0);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         bit rd, bst, ack, err;
         if (!m_act) begin
            rd  = ($urandom_range(0, 2) == 0);
            ack = ($urandom_range(0, 1) == 0);
            err = ($urandom_range(0, 9) == 0);
         end else begin
            rd  = ($urandom_range(0, 29) != 0);
            ack = ($urandom_range(0, 2) != 0);
            err = ($urandom_range(0, 19) == 0);
         end
         bst = ($urandom_range(0, 1) == 1);
         step(rd, bst, $urandom, ack, err, $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
